// File: rtl/nanorv32_mem_arbiter.sv
// Merges the nanorv32 code-fetch and data ports onto one single-ported memory.
// Data has priority; a bounded burst counter guarantees code fetch progress.
module nanorv32_mem_arbiter #(
  parameter int ADDR_MSB       = 31,
  parameter int DATA_MSB       = 31,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_MSB:0] cpu_codemem_addr,
  input  logic              cpu_codemem_req,
  output logic [DATA_MSB:0] codemem_cpu_rdata,
  output logic              codemem_cpu_ack,
  input  logic [ADDR_MSB:0] cpu_datamem_addr,
  input  logic [DATA_MSB:0] cpu_datamem_wdata,
  input  logic [3:0]        cpu_datamem_bytesel,
  input  logic              cpu_datamem_req,
  output logic [DATA_MSB:0] datamem_cpu_rdata,
  output logic              datamem_cpu_ack,
  output logic [ADDR_MSB:0] mem_addr,
  output logic [DATA_MSB:0] mem_wdata,
  output logic [3:0]        mem_bytesel,
  output logic              mem_req,
  input  logic [DATA_MSB:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        arb_grant
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_CODE   = 2'b01;
  localparam logic [1:0] ST_DATA   = 2'b10;
  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  logic [1:0] state_r, state_nxt;
  logic [3:0] data_streak_r, streak_nxt;
  logic       code_done, data_done, arbitrate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      data_streak_r <= 4'd0;
    end else begin
      state_r       <= state_nxt;
      data_streak_r <= streak_nxt;
    end
  end

  always_comb begin
    code_done = (state_r == ST_CODE) && mem_ack;
    data_done = (state_r == ST_DATA) && mem_ack;
    arbitrate = !((state_r == ST_CODE) || (state_r == ST_DATA)) || mem_ack;

    streak_nxt = data_streak_r;
    if (code_done) begin
      streak_nxt = 4'd0;
    end else if (data_done) begin
      if (!cpu_codemem_req)
        streak_nxt = 4'd0;
      else if (data_streak_r < BURST_MAX)
        streak_nxt = data_streak_r + 4'd1;
    end

    // Compare against the post-update streak so a burst is exactly DATA_BURST_MAX long.
    state_nxt = state_r;
    if (arbitrate) begin
      if (cpu_datamem_req && (!cpu_codemem_req || (streak_nxt != BURST_MAX)))
        state_nxt = ST_DATA;
      else if (cpu_codemem_req)
        state_nxt = ST_CODE;
      else
        state_nxt = ST_IDLE;
    end else if ((state_r == ST_CODE) && !cpu_codemem_req) begin
      state_nxt = ST_IDLE;
    end else if ((state_r == ST_DATA) && !cpu_datamem_req) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_bytesel = 4'b0000;
    mem_req     = 1'b0;
    case (state_r)
      ST_CODE: begin
        mem_addr = cpu_codemem_addr;
        mem_req  = cpu_codemem_req;
      end
      ST_DATA: begin
        mem_addr    = cpu_datamem_addr;
        mem_wdata   = cpu_datamem_wdata;
        mem_bytesel = cpu_datamem_bytesel;
        mem_req     = cpu_datamem_req;
      end
      default: ;
    endcase
    codemem_cpu_ack   = code_done;
    datamem_cpu_ack   = data_done;
    codemem_cpu_rdata = mem_rdata;
    datamem_cpu_rdata = mem_rdata;
    arb_grant         = state_r;
  end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// Directed vector table plus hand-written reset sequences for the memory arbiter.
module tb_nanorv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_codemem_addr;
  logic        cpu_codemem_req;
  logic [31:0] codemem_cpu_rdata;
  logic        codemem_cpu_ack;
  logic [31:0] cpu_datamem_addr;
  logic [31:0] cpu_datamem_wdata;
  logic [3:0]  cpu_datamem_bytesel;
  logic        cpu_datamem_req;
  logic [31:0] datamem_cpu_rdata;
  logic        datamem_cpu_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bytesel;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  arb_grant;

  int n_cmp = 0;
  int n_bad = 0;

  nanorv32_mem_arbiter #(.ADDR_MSB(31), .DATA_MSB(31), .DATA_BURST_MAX(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cpu_codemem_addr    (cpu_codemem_addr),
    .cpu_codemem_req     (cpu_codemem_req),
    .codemem_cpu_rdata   (codemem_cpu_rdata),
    .codemem_cpu_ack     (codemem_cpu_ack),
    .cpu_datamem_addr    (cpu_datamem_addr),
    .cpu_datamem_wdata   (cpu_datamem_wdata),
    .cpu_datamem_bytesel (cpu_datamem_bytesel),
    .cpu_datamem_req     (cpu_datamem_req),
    .datamem_cpu_rdata   (datamem_cpu_rdata),
    .datamem_cpu_ack     (datamem_cpu_ack),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_bytesel         (mem_bytesel),
    .mem_req             (mem_req),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .arb_grant           (arb_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr;
    logic [31:0] ca;
    logic        dr;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  bs;
    logic        ack;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  ebs;
    logic        ecack;
    logic        edack;
    logic [1:0]  eg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic cr, input logic [31:0] ca, input logic dr,
                              input logic [31:0] da, input logic [31:0] wd, input logic [3:0] bs,
                              input logic ack, input logic [31:0] rd, input logic ereq,
                              input logic [31:0] eaddr, input logic [31:0] ewd, input logic [3:0] ebs,
                              input logic ecack, input logic edack, input logic [1:0] eg);
    vec_t v;
    v.cr = cr; v.ca = ca; v.dr = dr; v.da = da; v.wd = wd; v.bs = bs;
    v.ack = ack; v.rd = rd; v.ereq = ereq; v.eaddr = eaddr; v.ewd = ewd;
    v.ebs = ebs; v.ecack = ecack; v.edack = edack; v.eg = eg;
    tbl.push_back(v);
  endfunction

  function automatic logic [136:0] outs();
    return {mem_req, mem_addr, mem_wdata, mem_bytesel, codemem_cpu_ack, datamem_cpu_ack,
            arb_grant, codemem_cpu_rdata, datamem_cpu_rdata};
  endfunction

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [31:0] ca, input logic dr, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] bs, input logic ack,
                       input logic [31:0] rd);
    cpu_codemem_req = cr; cpu_codemem_addr = ca;
    cpu_datamem_req = dr; cpu_datamem_addr = da;
    cpu_datamem_wdata = wd; cpu_datamem_bytesel = bs;
    mem_ack = ack; mem_rdata = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h77);
    #3;
    chk("reset_outputs", outs(), {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 32'h77, 32'h77});

    // code-only, zero-wait slave
    add(1, 32'h0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0, 2'd0);
    add(1, 32'h0, 0, 0, 0, 0, 1, 32'h11111111, 1, 32'h0, 0, 0, 1, 0, 2'd1);
    add(1, 32'h4, 0, 0, 0, 0, 1, 32'h22222222, 1, 32'h4, 0, 0, 1, 0, 2'd1);
    add(1, 32'h8, 0, 0, 0, 0, 1, 32'h33333333, 1, 32'h8, 0, 0, 1, 0, 2'd1);
    add(0, 32'hC, 0, 0, 0, 0, 0, 32'h0,        0, 32'hC, 0, 0, 0, 0, 2'd1);
    // data write with two wait states
    add(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,  0, 32'h0,   32'h0,        4'h0, 0, 0, 2'd0);
    add(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h44, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 2'd2);
    add(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h44, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 2'd2);
    add(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 32'h55, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 1, 2'd2);
    add(0, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,  0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 2'd0);
    // contention: D,D,D,D,C,D,D,D,D,C
    add(1, 32'h200, 1, 32'h300, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 2'd0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        add(1, 32'h200, 1, 32'h300, 32'hA5A5A5A5, 4'h3, 1, 32'h600 + 32'(k),
            1, 32'h300, 32'hA5A5A5A5, 4'h3, 0, 1, 2'd2);
      add(1, 32'h200, 1, 32'h300, 32'hA5A5A5A5, 4'h3, 1, 32'h700,
          1, 32'h200, 32'h0, 4'h0, 1, 0, 2'd1);
    end
    // abort of a data grant with code pending
    add(1, 32'h200, 0, 32'h300, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 0, 32'h300, 32'hA5A5A5A5, 4'h3, 0, 0, 2'd2);
    add(1, 32'h200, 0, 32'h300, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 2'd0);
    add(1, 32'h200, 0, 0, 0, 0, 1, 32'h88, 1, 32'h200, 0, 0, 1, 0, 2'd1);
    add(0, 32'h200, 0, 0, 0, 0, 0, 32'h0,  0, 32'h200, 0, 0, 0, 0, 2'd1);
    // stray ack while idle
    add(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 2'd0);

    #9;
    rst_n = 1'b1;
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].cr, tbl[i].ca, tbl[i].dr, tbl[i].da, tbl[i].wd, tbl[i].bs, tbl[i].ack, tbl[i].rd);
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].ereq, tbl[i].eaddr, tbl[i].ewd, tbl[i].ebs, tbl[i].ecack, tbl[i].edack,
           tbl[i].eg, tbl[i].rd, tbl[i].rd});
      @(posedge clk);
      #1;
    end

    // asynchronous reset in the middle of a data grant
    drive(1'b0, 32'h0, 1'b1, 32'h400, 32'h12345678, 4'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("data_granted_before_reset", {135'd0, mem_req, arb_grant[1]}, {135'd0, 1'b1, 1'b1});
    #2;
    mem_ack = 1'b1;
    mem_rdata = 32'h9ABC;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_transfer", outs(), {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 32'h9ABC, 32'h9ABC});
    @(posedge clk);
    #2;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_after_reset%0d", c), outs(),
          {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
